// File: rtl/csr_counter_file.sv
// Machine/user counter CSR file: mcycle, minstret, hpm counters, mcountinhibit. Reads are zero-latency; writes land on the next edge.
// No backpressure: every access completes in its cycle. Optional hpm counters are built only when CSR_HPM_EN is defined.
module csr_counter_file #(
  parameter int NUM_HPM = 4,
  parameter int CNT_W   = 64
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [11:0]                             csr_addr_in,
  input  logic [1:0]                              csr_op_in,
  input  logic [31:0]                             csr_wdata_in,
  input  logic                                    instret_inc_in,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_in,
  input  logic [63:0]                             mtime_in,
  output logic [31:0]                             csr_rdata_out,
  output logic                                    csr_illegal_out,
  output logic [31:0]                             mcountinhibit_out
);

`ifdef CSR_HPM_EN
  localparam int NHPM = NUM_HPM;
`else
  localparam int NHPM = 0;
`endif
  // Writable inhibit bits: cycle, instret and one per implemented hpm counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NHPM) - 32'h1) << 3);

  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;
  logic [31:0]      inhibit;

  logic [4:0]  idx;
  logic        hi;
  logic        bank_m;
  logic        bank_u;
  logic        bank;
  logic        is_inh;
  logic        sel_cyc;
  logic        sel_time;
  logic        sel_ret;
  logic        hpm_sel;
  logic [63:0] hpm_rd;
  logic        implemented;
  logic        wr_en;
  logic [63:0] cur;
  logic [31:0] old_half;
  logic [31:0] new_half;
  logic [63:0] wr_full;

  assign idx         = csr_addr_in[4:0];
  assign hi          = csr_addr_in[7];
  assign bank_m      = (csr_addr_in[11:8] == 4'hB) && (csr_addr_in[6:5] == 2'b00);
  assign bank_u      = (csr_addr_in[11:8] == 4'hC) && (csr_addr_in[6:5] == 2'b00);
  assign bank        = bank_m || bank_u;
  assign is_inh      = (csr_addr_in == 12'h320);
  assign sel_cyc     = bank && (idx == 5'd0);
  assign sel_time    = bank_u && (idx == 5'd1);
  assign sel_ret     = bank && (idx == 5'd2);
  assign implemented = sel_cyc || sel_time || sel_ret || hpm_sel || is_inh;
  // User-bank shadows are read-only, so only machine-bank and inhibit writes commit.
  assign wr_en       = (csr_op_in != 2'b00) && implemented && !bank_u;

  always_comb begin
    cur = '0;
    if (sel_cyc)  cur = 64'(mcycle);
    if (sel_time) cur = mtime_in;
    if (sel_ret)  cur = 64'(minstret);
    if (hpm_sel)  cur = hpm_rd;
    if (is_inh)   cur = {32'h0, inhibit};
    old_half = hi ? cur[63:32] : cur[31:0];
    case (csr_op_in)
      2'b01:   new_half = csr_wdata_in;
      2'b10:   new_half = old_half | csr_wdata_in;
      2'b11:   new_half = old_half & ~csr_wdata_in;
      default: new_half = old_half;
    endcase
    wr_full = hi ? {new_half, cur[31:0]} : {cur[63:32], new_half};
  end

  assign csr_rdata_out     = implemented ? old_half : 32'h0;
  assign csr_illegal_out   = !implemented || (bank_u && (csr_op_in != 2'b00));
  assign mcountinhibit_out = inhibit;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
    end else begin
      if (wr_en && sel_cyc)
        mcycle <= CNT_W'(wr_full);
      else if (!inhibit[0])
        mcycle <= mcycle + CNT_W'(1);

      if (wr_en && sel_ret)
        minstret <= CNT_W'(wr_full);
      else if (instret_inc_in && !inhibit[2])
        minstret <= minstret + CNT_W'(1);

      if (wr_en && is_inh)
        inhibit <= new_half & INH_MASK;
    end
  end

  generate
    if (NHPM > 0) begin : g_hpm
      logic [CNT_W-1:0] cnt [NHPM];

      always_comb begin
        hpm_sel = 1'b0;
        hpm_rd  = '0;
        for (int k = 0; k < NHPM; k++) begin
          if (bank && (idx == 5'(k + 3))) begin
            hpm_sel = 1'b1;
            hpm_rd  = 64'(cnt[k]);
          end
        end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int k = 0; k < NHPM; k++) cnt[k] <= '0;
        end else begin
          for (int k = 0; k < NHPM; k++) begin
            if (wr_en && bank && (idx == 5'(k + 3)))
              cnt[k] <= CNT_W'(wr_full);
            else if (hpm_event_in[k] && !inhibit[k + 3])
              cnt[k] <= cnt[k] + CNT_W'(1);
          end
        end
      end
    end else begin : g_no_hpm
      logic unused_evt;
      assign hpm_sel    = 1'b0;
      assign hpm_rd     = '0;
      assign unused_evt = ^hpm_event_in;
    end
  endgenerate

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file: reset, carry, read-modify-write ops, inhibit, read-only and illegal
// decode, hpm counters (when CSR_HPM_EN), and asynchronous reset in mid-write.
module tb_csr_counter_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic        instret_inc;
  logic [3:0]  hpm_event;
  logic [63:0] mtime;
  logic [31:0] rdata;
  logic        illegal;
  logic [31:0] inh_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef CSR_HPM_EN
  localparam logic [31:0] INH_ALL = 32'h0000007D;
`else
  localparam logic [31:0] INH_ALL = 32'h00000005;
`endif

  csr_counter_file dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .csr_addr_in       (addr),
    .csr_op_in         (op),
    .csr_wdata_in      (wdata),
    .instret_inc_in    (instret_inc),
    .hpm_event_in      (hpm_event),
    .mtime_in          (mtime),
    .csr_rdata_out     (rdata),
    .csr_illegal_out   (illegal),
    .mcountinhibit_out (inh_out)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want %h", rdata, 32'h0); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else pass_cnt++;
    total_cnt++; if (inh_out !== 32'h0) $display("FAIL rst_inhibit: got %h want 0", inh_out); else pass_cnt++;
    repeat (3) cycle();
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_hold: got %h want 0", rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cycle();
    total_cnt++; if (rdata !== 32'h0000000A) $display("FAIL idle10_b00: got %h want %h", rdata, 32'hA); else pass_cnt++;
    addr = 12'hB80; #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL idle10_b80: got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL idle10_illegal: got %b want 0", illegal); else pass_cnt++;
  endtask

  task automatic test_carry_ops();
    addr = 12'hB00; op = 2'b01; wdata = 32'hFFFFFFFF;
    cycle();
    addr = 12'hB80; wdata = 32'h0;
    cycle();
    op = 2'b00;
    cycle();
    total_cnt++; if (rdata !== 32'h1) $display("FAIL carry_hi: got %h want 1", rdata); else pass_cnt++;
    addr = 12'hB00; #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL carry_lo: got %h want 0", rdata); else pass_cnt++;
    op = 2'b01; wdata = 32'h55; #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL prewrite_val: got %h want 0", rdata); else pass_cnt++;
    cycle();
    op = 2'b10; wdata = 32'h100; #1;
    total_cnt++; if (rdata !== 32'h55) $display("FAIL write_op: got %h want %h", rdata, 32'h55); else pass_cnt++;
    cycle();
    op = 2'b11; wdata = 32'h5; #1;
    total_cnt++; if (rdata !== 32'h155) $display("FAIL set_op: got %h want %h", rdata, 32'h155); else pass_cnt++;
    cycle();
    op = 2'b00; #1;
    total_cnt++; if (rdata !== 32'h150) $display("FAIL clear_op: got %h want %h", rdata, 32'h150); else pass_cnt++;
    cycle();
    total_cnt++; if (rdata !== 32'h151) $display("FAIL resume_count: got %h want %h", rdata, 32'h151); else pass_cnt++;
    addr = 12'hB80; #1;
    total_cnt++; if (rdata !== 32'h1) $display("FAIL hi_kept: got %h want 1", rdata); else pass_cnt++;
  endtask

  task automatic test_inhibit();
    addr = 12'hB02; op = 2'b00; instret_inc = 1'b1;
    repeat (3) cycle();
    total_cnt++; if (rdata !== 32'h3) $display("FAIL minstret3: got %h want 3", rdata); else pass_cnt++;
    addr = 12'hC02; #1;
    total_cnt++; if (rdata !== 32'h3) $display("FAIL instret_shadow: got %h want 3", rdata); else pass_cnt++;
    addr = 12'hB00; op = 2'b01; wdata = 32'h1000;
    cycle();
    addr = 12'h320; wdata = 32'h5;
    cycle();
    op = 2'b00;
    repeat (8) cycle();
    total_cnt++; if (rdata !== 32'h5) $display("FAIL inh_read: got %h want 5", rdata); else pass_cnt++;
    total_cnt++; if (inh_out !== 32'h5) $display("FAIL inh_out: got %h want 5", inh_out); else pass_cnt++;
    addr = 12'hB00; #1;
    total_cnt++; if (rdata !== 32'h1001) $display("FAIL mcycle_frozen: got %h want %h", rdata, 32'h1001); else pass_cnt++;
    addr = 12'hB02; #1;
    total_cnt++; if (rdata !== 32'h5) $display("FAIL minstret_frozen: got %h want 5", rdata); else pass_cnt++;
    instret_inc = 1'b0;
    addr = 12'h320; op = 2'b01; wdata = 32'hFFFFFFFF;
    cycle();
    op = 2'b00; #1;
    total_cnt++; if (rdata !== INH_ALL) $display("FAIL inh_mask: got %h want %h", rdata, INH_ALL); else pass_cnt++;
    op = 2'b11;
    cycle();
    op = 2'b00; #1;
    total_cnt++; if (inh_out !== 32'h0) $display("FAIL inh_clear: got %h want 0", inh_out); else pass_cnt++;
    cycle();
    addr = 12'hB00; #1;
    total_cnt++; if (rdata !== 32'h1002) $display("FAIL mcycle_resume: got %h want %h", rdata, 32'h1002); else pass_cnt++;
  endtask

  task automatic test_readonly_illegal();
    addr = 12'hC00; op = 2'b01; wdata = 32'h1234; #1;
    total_cnt++; if (illegal !== 1'b1) $display("FAIL ro_write_illegal: got %b want 1", illegal); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h1002) $display("FAIL ro_shadow_read: got %h want %h", rdata, 32'h1002); else pass_cnt++;
    cycle();
    op = 2'b00; #1;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL ro_read_legal: got %b want 0", illegal); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h1003) $display("FAIL ro_no_write: got %h want %h", rdata, 32'h1003); else pass_cnt++;
    addr = 12'hC01; #1;
    total_cnt++; if (rdata !== 32'h01234567) $display("FAIL time_lo: got %h want %h", rdata, 32'h01234567); else pass_cnt++;
    addr = 12'hC81; #1;
    total_cnt++; if (rdata !== 32'h89ABCDEF) $display("FAIL time_hi: got %h want %h", rdata, 32'h89ABCDEF); else pass_cnt++;
    addr = 12'hB01; #1;
    total_cnt++; if (illegal !== 1'b1 || rdata !== 32'h0) $display("FAIL b01_unimpl: got ill=%b rd=%h want ill=1 rd=0", illegal, rdata); else pass_cnt++;
    addr = 12'h7C0; op = 2'b01; wdata = 32'hFFFF; #1;
    total_cnt++; if (illegal !== 1'b1 || rdata !== 32'h0) $display("FAIL 7c0_unimpl: got ill=%b rd=%h want ill=1 rd=0", illegal, rdata); else pass_cnt++;
    cycle();
    addr = 12'hB20; op = 2'b00; #1;
    total_cnt++; if (illegal !== 1'b1) $display("FAIL b20_unimpl: got %b want 1", illegal); else pass_cnt++;
    addr = 12'hB00; #1;
    total_cnt++; if (rdata !== 32'h1004) $display("FAIL after_illegal: got %h want %h", rdata, 32'h1004); else pass_cnt++;
  endtask

  task automatic test_hpm();
    addr = 12'hB04; op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      hpm_event = 4'b0010;
      cycle();
      hpm_event = 4'b0000;
      cycle();
    end
`ifdef CSR_HPM_EN
    total_cnt++; if (rdata !== 32'h3) $display("FAIL hpm4_count: got %h want 3", rdata); else pass_cnt++;
    addr = 12'hC04; #1;
    total_cnt++; if (rdata !== 32'h3) $display("FAIL hpm4_shadow: got %h want 3", rdata); else pass_cnt++;
    addr = 12'hB03; #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL hpm3_idle: got %h want 0", rdata); else pass_cnt++;
    addr = 12'hB07; #1;
    total_cnt++; if (illegal !== 1'b1 || rdata !== 32'h0) $display("FAIL hpm7_unimpl: got ill=%b rd=%h want ill=1 rd=0", illegal, rdata); else pass_cnt++;
    addr = 12'hB04; op = 2'b11; wdata = 32'h1;
    cycle();
    op = 2'b00; #1;
    total_cnt++; if (rdata !== 32'h2) $display("FAIL hpm4_clear: got %h want 2", rdata); else pass_cnt++;
`else
    total_cnt++; if (illegal !== 1'b1 || rdata !== 32'h0) $display("FAIL hpm4_absent: got ill=%b rd=%h want ill=1 rd=0", illegal, rdata); else pass_cnt++;
    addr = 12'hC03; #1;
    total_cnt++; if (illegal !== 1'b1) $display("FAIL hpm3_shadow_absent: got %b want 1", illegal); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    addr = 12'hB00; op = 2'b01; wdata = 32'h100;
    cycle();
    addr = 12'hB80; wdata = 32'h0;
    cycle();
    addr = 12'hB00; op = 2'b00; #1;
    total_cnt++; if (rdata !== 32'h100) $display("FAIL pre_reset: got %h want %h", rdata, 32'h100); else pass_cnt++;
    op = 2'b01; wdata = 32'h777; #2;
    rst_n = 1'b0; #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL async_clear: got %h want 0", rdata); else pass_cnt++;
    cycle();
    total_cnt++; if (rdata !== 32'h0) $display("FAIL write_discarded: got %h want 0", rdata); else pass_cnt++;
    op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    total_cnt++; if (rdata !== 32'h1) $display("FAIL first_count: got %h want 1", rdata); else pass_cnt++;
  endtask

  initial begin
    rst_n       = 1'b0;
    addr        = 12'hB00;
    op          = 2'b00;
    wdata       = 32'h0;
    instret_inc = 1'b0;
    hpm_event   = 4'b0000;
    mtime       = 64'h89ABCDEF_01234567;
    test_reset();
    test_carry_ops();
    test_inhibit();
    test_readonly_illegal();
    test_hpm();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/csr_counter_file.md
CSR_COUNTER_FILE -- requirements
Module: csr_counter_file

Interface
REQ-001 Parameter NUM_HPM, default 4, number of hpmcounter3..(2+NUM_HPM) implemented, legal range 0..29.
REQ-002 Parameter CNT_W, default 64, counter width, legal range 33..64.
REQ-003 clk_in  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 csr_addr_in  input  12  CSR address for read and write.
REQ-006 csr_op_in  input  2  00 none, 01 write, 10 set, 11 clear.
REQ-007 csr_wdata_in  input  32  write/set/clear operand.
REQ-008 instret_inc_in  input  1  one instruction retired this cycle.
REQ-009 hpm_event_in  input  max(NUM_HPM,1)  bit k = event for hpmcounter(3+k).
REQ-010 mtime_in  input  64  platform timer value, read-only here.
REQ-011 csr_rdata_out  output  32  read data for csr_addr_in.
REQ-012 csr_illegal_out  output  1  access to unimplemented address, or write op to read-only address.
REQ-013 mcountinhibit_out  output  32  current mcountinhibit value.

Function
REQ-014 Implemented: mcycle(B00/B80), minstret(B02/B82), mhpmcounterN(B03+/B83+), mcountinhibit(320), shadows cycle(C00/C80), time(C01/C81), instret(C02/C82), hpmcounterN(C03+/C83+).
REQ-015 mcycle increments by 1 every cycle while mcountinhibit[0]=0.
REQ-016 minstret increments by 1 in cycles where instret_inc_in=1 and mcountinhibit[2]=0.
REQ-017 hpmcounter(3+k) increments by 1 in cycles where hpm_event_in[k]=1 and mcountinhibit[3+k]=0.
REQ-018 Counters wrap from 2^CNT_W-1 to 0 without flag.
REQ-019 csr_rdata_out is combinational from current registered state, i.e. pre-write value in a write cycle (zero latency).
REQ-020 Low address returns counter[31:0]; high (+0x80) returns counter[CNT_W-1:32] zero-extended to 32 bits.
REQ-021 Time/timeh return mtime_in[31:0]/[63:32].
REQ-022 Write result = wdata (01), old|wdata (10), old&~wdata (11), applied to the addressed 32-bit half only; bits above CNT_W-1 discarded.
REQ-023 In a write cycle the targeted counter takes the written half plus its unwritten half unchanged and does not increment; all other counters increment normally.
REQ-024 A write to mcountinhibit takes effect for increments from the next cycle onward.
REQ-025 mcountinhibit bit 1 and bits above 2+NUM_HPM are hardwired 0 and read as 0.
REQ-026 Write op to any 0xCxx address sets csr_illegal_out=1 combinationally and changes no state.
REQ-027 Any unimplemented address sets csr_illegal_out=1, reads 0, writes ignored.
REQ-028 csr_op_in=00 never asserts csr_illegal_out for an implemented address and never changes state.

Reset
REQ-029 rst_n_in=0 asynchronously clears all counters and mcountinhibit to 0; csr_rdata_out follows the cleared state.
REQ-030 Increments and writes are suppressed while rst_n_in=0; counting resumes on the first rising edge after deassertion.
REQ-031 Reset asserted mid-write discards the write.

Configuration
REQ-032 Macro CSR_HPM_EN defined: hpmcounters and their inhibit bits implemented per NUM_HPM.
REQ-033 CSR_HPM_EN undefined: no hpm registers exist, NUM_HPM ignored, hpm addresses illegal (REQ-027), inhibit bits 3..31 hardwired 0, hpm_event_in unused.

Verification
REQ-034 Reset release, 10 idle cycles, read B00 -> 0x0000000A; read B80 -> 0; csr_illegal_out=0.
REQ-035 Write B00=0xFFFFFFFF, B80=0x00000000, idle 1 cycle -> B80 reads 0x00000001, B00 reads 0x00000000 (carry across halves).
REQ-036 Write 320=0x00000005, then 8 cycles with instret_inc_in=1 -> mcycle and minstret frozen; 320 reads 0x00000005.
REQ-037 Write op 01 to C00 with 0x1234 -> csr_illegal_out=1, mcycle continues counting unchanged.
REQ-038 CSR_HPM_EN, NUM_HPM=4: pulse hpm_event_in[1] 3 times, read B04 -> 3; read B07 -> 0, csr_illegal_out=1; clear-op on B04 with 0x1 -> B04 reads 2.
REQ-039 Assert rst_n_in mid-count with mcycle=0x100 -> outputs 0 immediately without a clock edge.
